// File: rtl/sync_pkg.sv
// Shared limits and helpers for the multi-flop synchronizer slice.
package sync_pkg;

  localparam int MAX_CH         = 32;
  localparam int MIN_STAGES     = 2;
  localparam int MAX_STAGES     = 5;
  localparam int MAX_FILTER_LEN = 255;

  // A bypassed filter still gets a 1-bit counter width so declarations stay legal.
  function automatic int counterWidth(input int filterLen);
    return (filterLen < 1) ? 1 : $clog2(filterLen + 1);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel's glitch filter and edge detector.
// Sits behind that channel's synchronizer chain.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   FILTER_LEN = 0,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic chain_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = counterWidth(FILTER_LEN);

  logic prev_q;

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign sync_o = chain_i;
    end else begin : g_filter
      localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;

      // Any agreement, or a completed qualification, restarts the count from zero.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (chain_i != filt_q) begin
          if (cnt_q == LAST) begin
            filt_d = chain_i;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q  <= '0;
          filt_q <= RESET_VAL;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign sync_o = filt_q;
    end
  endgenerate

  // prev_q resets to the same value as the output, so leaving reset never pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sync_o;
    end
  end

  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/synchronizer_nff.sv
// N-channel multi-flop synchronizer with optional per-channel glitch filter and edge pulses.
// Channels are independent; multi-bit buses must be Gray-coded upstream.
module synchronizer_nff
  import sync_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                STAGES     = 2,
  parameter int                FILTER_LEN = 0,
  parameter logic [NUM_CH-1:0] RESET_VAL  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] data_i,
  output logic [NUM_CH-1:0] data_sync_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              any_change_o
);

  generate
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_badNumCh
      $error("synchronizer_nff: NUM_CH out of range 1..32");
    end
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_badStages
      $error("synchronizer_nff: STAGES out of range 2..5");
    end
    if (FILTER_LEN < 0 || FILTER_LEN > MAX_FILTER_LEN) begin : g_badFilterLen
      $error("synchronizer_nff: FILTER_LEN out of range 0..255");
    end
  endgenerate

  // Bare flop-to-flop chain so synthesis can tag the stages as synchronizer cells.
  logic [NUM_CH-1:0] chain_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        chain_q[s] <= RESET_VAL;
      end
    end else begin
      chain_q[0] <= data_i;
      for (int s = 1; s < STAGES; s++) begin
        chain_q[s] <= chain_q[s-1];
      end
    end
  end

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      sync_filter_ch #(
        .FILTER_LEN (FILTER_LEN),
        .RESET_VAL  (RESET_VAL[ch])
      ) u_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .chain_i (chain_q[STAGES-1][ch]),
        .sync_o  (data_sync_o[ch]),
        .rise_o  (rise_o[ch]),
        .fall_o  (fall_o[ch])
      );
    end
  endgenerate

  assign any_change_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_synchronizer_nff.sv
// Randomized self-checking bench for synchronizer_nff.
// Three configurations run side by side against a history-based reference model.
module tb_synchronizer_nff;

  localparam int NDUT = 3;
  localparam int HIST = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic [3:0]  data0, data1;
  logic [31:0] data2;
  logic [3:0]  sync0, rise0, fall0, sync1, rise1, fall1;
  logic [31:0] sync2, rise2, fall2;
  logic        any0, any1, any2;

  synchronizer_nff #(.NUM_CH(4), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(4'b1010)) dut0 (
    .clk_i(clk), .rst_i(rst0), .data_i(data0), .data_sync_o(sync0),
    .rise_o(rise0), .fall_o(fall0), .any_change_o(any0));

  synchronizer_nff #(.NUM_CH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b0000)) dut1 (
    .clk_i(clk), .rst_i(rst1), .data_i(data1), .data_sync_o(sync1),
    .rise_o(rise1), .fall_o(fall1), .any_change_o(any1));

  synchronizer_nff #(.NUM_CH(32), .STAGES(3), .FILTER_LEN(3), .RESET_VAL(32'hA5C3_0F96)) dut2 (
    .clk_i(clk), .rst_i(rst2), .data_i(data2), .data_sync_o(sync2),
    .rise_o(rise2), .fall_o(fall2), .any_change_o(any2));

  int          stagesOf [NDUT] = '{3, 2, 3};
  int          lenOf    [NDUT] = '{0, 4, 3};
  logic [31:0] rvOf     [NDUT] = '{32'hA, 32'h0, 32'hA5C3_0F96};
  logic [31:0] maskOf   [NDUT] = '{32'hF, 32'hF, 32'hFFFF_FFFF};

  // Per-edge record of what each DUT sampled, plus the model's filtered value after each edge.
  logic [31:0] dataH [NDUT][HIST];
  bit          rstH  [NDUT][HIST];
  logic [31:0] filtH [NDUT][HIST];
  int          edgeNo = -1;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checking    = 1'b0;

  // The last synchronizer stage holds the input sampled STAGES-1 edges earlier,
  // unless a reset landed anywhere inside that window.
  function automatic logic [31:0] chainAt(input int d, input int e);
    if (e < 0) return rvOf[d];
    for (int j = 0; j < stagesOf[d]; j++) begin
      if (e - j < 0 || rstH[d][e-j]) return rvOf[d];
    end
    return dataH[d][e - stagesOf[d] + 1];
  endfunction

  function automatic logic [31:0] filtAt(input int d, input int e);
    if (e < 0) return rvOf[d];
    return filtH[d][e];
  endfunction

  // A bit flips once the chain has disagreed with it on L consecutive reset-free edges.
  function automatic logic [31:0] computeFilt(input int d, input int e);
    logic [31:0] prevVal, flipMask;
    if (rstH[d][e]) return rvOf[d];
    if (lenOf[d] == 0) return chainAt(d, e);
    prevVal  = filtAt(d, e - 1);
    flipMask = '1;
    for (int k = 0; k < lenOf[d]; k++) begin
      if (e - k < 0 || rstH[d][e-k]) flipMask = '0;
      else flipMask &= chainAt(d, e - k - 1) ^ prevVal;
    end
    return prevVal ^ flipMask;
  endfunction

  always @(posedge clk) begin
    edgeNo++;
    if (edgeNo >= HIST) begin
      $display("[TB] FAIL history: edge %0d exceeds model depth %0d", edgeNo, HIST);
      $fatal(1, "[TB] model history overflow");
    end
    dataH[0][edgeNo] = {28'b0, data0};
    dataH[1][edgeNo] = {28'b0, data1};
    dataH[2][edgeNo] = data2;
    rstH[0][edgeNo]  = rst0;
    rstH[1][edgeNo]  = rst1;
    rstH[2][edgeNo]  = rst2;
    for (int d = 0; d < NDUT; d++) begin
      filtH[d][edgeNo] = computeFilt(d, edgeNo);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    logic [31:0] expSync, expPrev, expRise, expFall;
    logic [31:0] oSync, oRise, oFall;
    logic        oAny;
    for (int d = 0; d < NDUT; d++) begin
      expSync = filtAt(d, edgeNo) & maskOf[d];
      expPrev = (rstH[d][edgeNo] ? rvOf[d] : filtAt(d, edgeNo - 1)) & maskOf[d];
      expRise = expSync & ~expPrev & maskOf[d];
      expFall = ~expSync & expPrev & maskOf[d];
      case (d)
        0:       begin oSync = {28'b0, sync0}; oRise = {28'b0, rise0}; oFall = {28'b0, fall0}; oAny = any0; end
        1:       begin oSync = {28'b0, sync1}; oRise = {28'b0, rise1}; oFall = {28'b0, fall1}; oAny = any1; end
        default: begin oSync = sync2;          oRise = rise2;          oFall = fall2;          oAny = any2; end
      endcase
      checkOutput($sformatf("dut%0d sync edge%0d", d, edgeNo), oSync, expSync);
      checkOutput($sformatf("dut%0d rise edge%0d", d, edgeNo), oRise, expRise);
      checkOutput($sformatf("dut%0d fall edge%0d", d, edgeNo), oFall, expFall);
      checkOutput($sformatf("dut%0d any edge%0d", d, edgeNo), {31'b0, oAny},
                  {31'b0, |(expRise | expFall)});
    end
  endtask

  // Advance to the falling edge after the next rising edge and compare every DUT to the model.
  task automatic applyStimulus();
    @(negedge clk);
    if (checking) checkModel();
  endtask

  int gapCnt   [32];
  int transCnt [32];
  int pulseCnt [32];

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    data0 = 4'b0101; data1 = 4'b0000; data2 = $urandom;
    repeat (4) applyStimulus();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    checking = 1'b1;

    // Reset value opposite to the held input: no pulses until the chain delivers it.
    applyStimulus();
    checkOutput("rel1 sync", {28'b0, sync0}, 32'hA);
    checkOutput("rel1 pulses", {24'b0, rise0, fall0}, 32'h0);
    checkOutput("rel1 dut1 sync", {28'b0, sync1}, 32'h0);
    checkOutput("rel1 dut2 sync", sync2, 32'hA5C3_0F96);
    applyStimulus();
    checkOutput("rel2 sync", {28'b0, sync0}, 32'hA);
    checkOutput("rel2 pulses", {24'b0, rise0, fall0}, 32'h0);
    applyStimulus();
    checkOutput("rel3 sync", {28'b0, sync0}, 32'h5);
    checkOutput("rel3 rise", {28'b0, rise0}, 32'h5);
    checkOutput("rel3 fall", {28'b0, fall0}, 32'hA);
    checkOutput("rel3 any", {31'b0, any0}, 32'h1);
    applyStimulus();
    checkOutput("rel4 pulses", {24'b0, rise0, fall0}, 32'h0);

    // Unfiltered 3-stage latency and single-cycle rise pulse.
    data0 = 4'b0000;
    repeat (5) applyStimulus();
    data0[0] = 1'b1;
    applyStimulus();
    checkOutput("lat k sync0", {31'b0, sync0[0]}, 32'h0);
    applyStimulus();
    checkOutput("lat k+1 sync0", {31'b0, sync0[0]}, 32'h0);
    applyStimulus();
    checkOutput("lat k+2 sync0", {31'b0, sync0[0]}, 32'h1);
    checkOutput("lat k+2 rise0", {31'b0, rise0[0]}, 32'h1);
    checkOutput("lat k+2 any", {31'b0, any0}, 32'h1);
    applyStimulus();
    checkOutput("lat k+3 rise0", {31'b0, rise0[0]}, 32'h0);
    checkOutput("lat k+3 sync0", {31'b0, sync0[0]}, 32'h1);

    // A 3-cycle glitch is one short of qualifying with L=4.
    data1[1] = 1'b1;
    repeat (3) applyStimulus();
    data1[1] = 1'b0;
    repeat (10) begin
      applyStimulus();
      checkOutput("glitch sync1", {28'b0, sync1}, 32'h0);
      checkOutput("glitch pulses1", {24'b0, rise1, fall1}, 32'h0);
    end

    // Exactly four cycles high qualifies and shows after edge k+5.
    data1[1] = 1'b1;
    repeat (4) applyStimulus();
    data1[1] = 1'b0;
    applyStimulus();
    checkOutput("qual k+4 sync1", {31'b0, sync1[1]}, 32'h0);
    applyStimulus();
    checkOutput("qual k+5 sync1", {31'b0, sync1[1]}, 32'h1);
    checkOutput("qual k+5 rise1", {28'b0, rise1}, 32'h2);
    repeat (12) applyStimulus();
    checkOutput("qual settle sync1", {28'b0, sync1}, 32'h0);

    // Reset mid-qualification drops the count and forces a full requalification.
    data1 = 4'b1111;
    repeat (4) applyStimulus();
    rst1 = 1'b1;
    applyStimulus();
    rst1 = 1'b0;
    checkOutput("midrst sync1", {28'b0, sync1}, 32'h0);
    checkOutput("midrst pulses1", {24'b0, rise1, fall1}, 32'h0);
    repeat (5) begin
      applyStimulus();
      checkOutput("requal wait sync1", {28'b0, sync1}, 32'h0);
    end
    applyStimulus();
    checkOutput("requal sync1", {28'b0, sync1}, 32'hF);
    checkOutput("requal rise1", {28'b0, rise1}, 32'hF);
    data1 = 4'b0000;
    repeat (12) applyStimulus();

    // Random traffic; dut2 channels toggle with enough spacing that every change must be reported.
    for (int ch = 0; ch < 32; ch++) begin
      gapCnt[ch] = 0; transCnt[ch] = 0; pulseCnt[ch] = 0;
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int ch = 0; ch < 32; ch++) begin
        if (gapCnt[ch] > 0) begin
          gapCnt[ch]--;
        end else if ($urandom_range(0, 3) == 0) begin
          data2[ch]    = ~data2[ch];
          transCnt[ch] = transCnt[ch] + 1;
          gapCnt[ch]   = stagesOf[2] + lenOf[2] + 2 + int'($urandom_range(0, 4));
        end
      end
      if ($urandom_range(0, 1) == 0) data0[$urandom_range(0, 3)] = ~data0[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) data1[$urandom_range(0, 3)] = ~data1[$urandom_range(0, 3)];
      rst0 = ($urandom_range(0, 99) == 0);
      rst1 = ($urandom_range(0, 79) == 0);
      applyStimulus();
      for (int ch = 0; ch < 32; ch++) begin
        pulseCnt[ch] = pulseCnt[ch] + int'(rise2[ch]) + int'(fall2[ch]);
      end
    end
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (15) begin
      applyStimulus();
      for (int ch = 0; ch < 32; ch++) begin
        pulseCnt[ch] = pulseCnt[ch] + int'(rise2[ch]) + int'(fall2[ch]);
      end
    end
    for (int ch = 0; ch < 32; ch++) begin
      checkOutput($sformatf("pulse count ch%0d", ch), pulseCnt[ch], transCnt[ch]);
    end
    checkOutput("final sync2", sync2, data2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
